lamp_fpu_sqrt_arbiter: RTL and testbench

- Shares one mantissa square-root / inverse-square-root core (`lampFPU_fractSqrt`) between `NUM_REQ` requesters.
- Accepts one request at a time under round-robin priority, issues a single start pulse to the core and waits for its `valid_o`.
- Buffers the 16-bit result and returns it on the granted requester's response handshake.
- Sits between the FPU issue logic and the iterative Goldschmidt core.

---
 rtl/lampFPU_pkg.sv | 20 ++
 rtl/lamp_fpu_rr_pick.sv | 31 +++
 rtl/lamp_fpu_sqrt_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_lamp_fpu_sqrt_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lampFPU_pkg.sv
// Shared FPU definitions used by the square-root arbiter.
package lampFPU_pkg;

   localparam int unsigned LAMP_FLOAT_F_DW  = 7;
   localparam int unsigned LAMP_APPROX_MULS = 3;

   // Cycles WAIT may last before the watchdog gives up on the core.
   localparam int unsigned LAMP_SQRT_ARB_WDOG_CYC = 2 * LAMP_APPROX_MULS + 8;

   localparam logic LAMP_SQRT_OP_SQRT    = 1'b0;
   localparam logic LAMP_SQRT_OP_INVSQRT = 1'b1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StResp  = 2'd3
   } lampSqrtArbState_t;

endpackage

// File: rtl/lamp_fpu_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module lamp_fpu_rr_pick #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   logic [IDX_W-1:0] cand;

   // Scan requesters starting at the pointer; the first hit wins.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         cand = IDX_W'((int'(ptr_i) + i) % int'(NUM_REQ));
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/lamp_fpu_sqrt_arbiter.sv
// Round-robin arbiter sharing one mantissa sqrt / invSqrt core between requesters.
// Optional watchdog on the core handshake: define LAMP_SQRT_ARB_WDOG_EN.
module lamp_fpu_sqrt_arbiter
   import lampFPU_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned F_W     = LAMP_FLOAT_F_DW + 2,
   parameter int unsigned R_W     = 2 * (LAMP_FLOAT_F_DW + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
`ifdef LAMP_SQRT_ARB_WDOG_EN
   output logic                   wdog_err_o,
`endif
   input  logic [NUM_REQ-1:0]     req_valid_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   input  logic [NUM_REQ-1:0]     req_op_i,
   input  logic [NUM_REQ*F_W-1:0] req_f_i,
   output logic [NUM_REQ-1:0]     rsp_valid_o,
   input  logic [NUM_REQ-1:0]     rsp_ready_i,
   output logic [R_W-1:0]         rsp_result_o,
   output logic                   busy_o,
   output logic                   core_doSqrt_o,
   output logic                   core_doInvSqrt_o,
   output logic [F_W-1:0]         core_f_o,
   input  logic [R_W-1:0]         core_result_i,
   input  logic                   core_valid_i
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   lampSqrtArbState_t state_q, state_d;

   logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]    idx_q;
   logic               op_q;
   logic [F_W-1:0]     f_q;
   logic [R_W-1:0]     result_q;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IdxW-1:0]    pick_idx;
   logic               pick_valid;
   logic               op_sel;
   logic [F_W-1:0]     f_sel;
   logic               wdog_expire;

   lamp_fpu_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IdxW)
   ) u_pick (
      .req_i   (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // Route the picked requester's op and operand with constant slices.
   always_comb begin
      op_sel = 1'b0;
      f_sel  = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         if (pick_idx == IdxW'(k)) begin
            op_sel = req_op_i[k];
            f_sel  = req_f_i[k*F_W +: F_W];
         end
      end
   end

`ifdef LAMP_SQRT_ARB_WDOG_EN
   localparam int unsigned WdogW = $clog2(LAMP_SQRT_ARB_WDOG_CYC);

   logic [WdogW-1:0] wdog_cnt_q;
   logic             wdog_err_q;

   assign wdog_expire = (state_q == StWait) && !core_valid_i &&
                        (wdog_cnt_q == WdogW'(LAMP_SQRT_ARB_WDOG_CYC - 1));

   // Count WAIT cycles; flag timeouts and core valids arriving outside WAIT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_cnt_q <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         if (state_q == StWait) begin
            wdog_cnt_q <= wdog_cnt_q + 1'b1;
         end else begin
            wdog_cnt_q <= '0;
         end
         if (wdog_expire || (core_valid_i && (state_q != StWait))) begin
            wdog_err_q <= 1'b1;
         end
      end
   end

   assign wdog_err_o = wdog_err_q;
`else
   assign wdog_expire = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and round-robin pointer update.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) state_d = StIssue;
         end
         StIssue: begin
            state_d = StWait;
         end
         StWait: begin
            if (core_valid_i || wdog_expire) state_d = StResp;
         end
         StResp: begin
            if (rsp_ready_i[idx_q]) begin
               state_d  = StIdle;
               rr_ptr_d = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from the current state.
   always_comb begin
      req_ready_o      = '0;
      rsp_valid_o      = '0;
      busy_o           = (state_q != StIdle);
      core_doSqrt_o    = 1'b0;
      core_doInvSqrt_o = 1'b0;
      unique case (state_q)
         StIdle:  req_ready_o = pick_gnt;
         StIssue: begin
            core_doSqrt_o    = (op_q == LAMP_SQRT_OP_SQRT);
            core_doInvSqrt_o = (op_q == LAMP_SQRT_OP_INVSQRT);
         end
         StWait:  ;
         StResp:  rsp_valid_o[idx_q] = 1'b1;
         default: ;
      endcase
   end

   // Latch the accepted request, capture the core result, advance the pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q <= '0;
         idx_q    <= '0;
         op_q     <= LAMP_SQRT_OP_SQRT;
         f_q      <= '0;
         result_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         if ((state_q == StIdle) && pick_valid) begin
            idx_q <= pick_idx;
            op_q  <= op_sel;
            f_q   <= f_sel;
         end
         if (state_q == StWait) begin
            if (core_valid_i) begin
               result_q <= core_result_i;
            end else if (wdog_expire) begin
               result_q <= '0;
            end
         end
      end
   end

   assign core_f_o     = f_q;
   assign rsp_result_o = result_q;

endmodule

// File: tb/tb_lamp_fpu_sqrt_arbiter.sv
// Bench for lamp_fpu_sqrt_arbiter with a behavioural Goldschmidt core stub.
module tb_lamp_fpu_sqrt_arbiter;
   import lampFPU_pkg::*;

   localparam int unsigned NR  = 2;
   localparam int unsigned FW  = 9;
   localparam int unsigned RW  = 16;
   localparam int          LAT = 2 * LAMP_APPROX_MULS + 2;

   logic             clk, rst;
   logic [NR-1:0]    req_valid_i, req_ready_o, req_op_i, rsp_valid_o, rsp_ready_i;
   logic [NR*FW-1:0] req_f_i;
   logic [RW-1:0]    rsp_result_o, core_result_i;
   logic             busy_o, core_doSqrt_o, core_doInvSqrt_o, core_valid_i;
   logic [FW-1:0]    core_f_o;
`ifdef LAMP_SQRT_ARB_WDOG_EN
   logic             wdog_err_o;
`endif

   lamp_fpu_sqrt_arbiter #(
      .NUM_REQ (NR),
      .F_W     (FW),
      .R_W     (RW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
`ifdef LAMP_SQRT_ARB_WDOG_EN
      .wdog_err_o       (wdog_err_o),
`endif
      .req_valid_i      (req_valid_i),
      .req_ready_o      (req_ready_o),
      .req_op_i         (req_op_i),
      .req_f_i          (req_f_i),
      .rsp_valid_o      (rsp_valid_o),
      .rsp_ready_i      (rsp_ready_i),
      .rsp_result_o     (rsp_result_o),
      .busy_o           (busy_o),
      .core_doSqrt_o    (core_doSqrt_o),
      .core_doInvSqrt_o (core_doInvSqrt_o),
      .core_f_o         (core_f_o),
      .core_result_i    (core_result_i),
      .core_valid_i     (core_valid_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [15:0] model(input logic op, input logic [8:0] f);
      return {f, 7'b0} ^ {7'b0, f} ^ (op ? 16'hC3C3 : 16'h1234);
   endfunction

   // Core stub: result valid 2*LAMP_APPROX_MULS cycles after the sampled start pulse.
   logic       force_valid, core_en, cs_op;
   logic [3:0] cs_cnt;
   logic [8:0] cs_f;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs_cnt <= '0;
      end else if (core_en && (core_doSqrt_o || core_doInvSqrt_o)) begin
         cs_cnt <= 4'(2 * LAMP_APPROX_MULS);
         cs_op  <= core_doInvSqrt_o;
         cs_f   <= core_f_o;
      end else if (cs_cnt != 0) begin
         cs_cnt <= cs_cnt - 1'b1;
      end
   end

   assign core_valid_i  = (cs_cnt == 4'd1) || force_valid;
   assign core_result_i = (cs_cnt == 4'd1) ? model(cs_op, cs_f) : 16'hDEAD;

   always @(negedge clk) begin
      if (core_doSqrt_o && core_doInvSqrt_o) begin
         n_tests++;
         n_fail++;
         $display("FAIL both_pulses: got doSqrt=1 doInvSqrt=1 want at most one");
      end
   end

   typedef struct {
      logic [1:0] mask;
      logic [1:0] ops;
      logic [8:0] f0;
      logic [8:0] f1;
      logic [1:0] gnt;
   } vec_t;

   typedef struct {
      logic [1:0]  gnt;
      logic [15:0] res;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Present a request, check the grant and the start pulse, push the expected response.
   task automatic start_req(input logic [1:0] mask, input logic [1:0] ops,
                            input logic [8:0] f0, input logic [8:0] f1,
                            input logic [1:0] gnt, input logic [1:0] rready,
                            input logic zero_res);
      bit   got = 0;
      logic op;
      exp_t e;
      @(posedge clk); #1;
      req_valid_i = mask;
      req_op_i    = ops;
      req_f_i     = {f1, f0};
      rsp_ready_i = rready;
      for (int i = 0; i < 16 && !got; i++) begin
         @(negedge clk);
         if (req_ready_o != 0) got = 1;
      end
      check("accept_gnt", 32'(req_ready_o), 32'(gnt));
      op    = gnt[1] ? ops[1] : ops[0];
      e.gnt = gnt;
      e.res = zero_res ? 16'h0 : model(op, gnt[1] ? f1 : f0);
      sb.push_back(e);
      @(posedge clk); #1;
      req_valid_i = '0;
      @(negedge clk);
      check("pulse_sqrt", 32'(core_doSqrt_o), 32'(!op));
      check("pulse_inv", 32'(core_doInvSqrt_o), 32'(op));
      check("busy_issue", 32'(busy_o), 32'd1);
   endtask

   // Wait (bounded) for the response and compare it against the scoreboard.
   task automatic finish_rsp(input int exp_lat);
      int   lat = 1;
      bit   got = 0;
      exp_t e;
      while (!got && lat < 64) begin
         @(negedge clk);
         lat++;
         if (rsp_valid_o != 0) got = 1;
      end
      check("rsp_latency", 32'(lat), 32'(exp_lat));
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("rsp_valid", 32'(rsp_valid_o), 32'(e.gnt));
         check("rsp_result", 32'(rsp_result_o), 32'(e.res));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{2'b01, 2'b00, 9'h080, 9'h000, 2'b01};
      vecs[1] = '{2'b11, 2'b10, 9'h0A5, 9'h1FF, 2'b10};
      vecs[2] = '{2'b11, 2'b10, 9'h0C4, 9'h13A, 2'b01};
      vecs[3] = '{2'b11, 2'b10, 9'h0F1, 9'h188, 2'b10};
      vecs[4] = '{2'b11, 2'b10, 9'h100, 9'h1C0, 2'b01};
      vecs[5] = '{2'b01, 2'b01, 9'h1C3, 9'h000, 2'b01};
      vecs[6] = '{2'b10, 2'b00, 9'h000, 9'h155, 2'b10};

      rst         = 1'b0;
      req_valid_i = '0;
      req_op_i    = '0;
      req_f_i     = '0;
      rsp_ready_i = '0;
      force_valid = 1'b0;
      core_en     = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_req_ready", 32'(req_ready_o), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_result", 32'(rsp_result_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_pulses", 32'({core_doSqrt_o, core_doInvSqrt_o}), 32'd0);
      check("rst_core_f", 32'(core_f_o), 32'd0);
`ifdef LAMP_SQRT_ARB_WDOG_EN
      check("rst_wdog", 32'(wdog_err_o), 32'd0);
`endif
      rst = 1'b1;

      // Table: single sqrt, alternating grants, wrap of the pointer.
      foreach (vecs[i]) begin
         start_req(vecs[i].mask, vecs[i].ops, vecs[i].f0, vecs[i].f1, vecs[i].gnt, 2'b11, 1'b0);
         finish_rsp(LAT);
         @(negedge clk);
         check("idle_after", 32'(busy_o), 32'd0);
      end

      // Response stalled 20 cycles while requester 1 waits; its rsp_ready is ignored.
      start_req(2'b01, 2'b00, 9'h033, 9'h000, 2'b01, 2'b00, 1'b0);
      finish_rsp(LAT);
      @(posedge clk); #1;
      req_valid_i = 2'b10;
      req_op_i    = 2'b10;
      req_f_i     = {9'h0F0, 9'h000};
      rsp_ready_i = 2'b10;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("stall_valid", 32'(rsp_valid_o), 32'h1);
         check("stall_result", 32'(rsp_result_o), 32'(model(1'b0, 9'h033)));
         check("stall_ready", 32'(req_ready_o), 32'h0);
      end
      @(posedge clk); #1;
      rsp_ready_i = 2'b11;
      @(negedge clk);
      @(negedge clk);
      check("stall_idle", 32'(busy_o), 32'd0);
      check("stall_next_gnt", 32'(req_ready_o), 32'h2);
      sb.push_back('{2'b10, model(1'b1, 9'h0F0)});
      @(posedge clk); #1;
      req_valid_i = '0;
      @(negedge clk);
      check("stall_next_inv", 32'(core_doInvSqrt_o), 32'd1);
      finish_rsp(LAT);
      @(negedge clk);

      // Reset in WAIT drops the operation; pointer restarts at 0.
      start_req(2'b10, 2'b00, 9'h000, 9'h101, 2'b10, 2'b11, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("wait_busy", 32'(busy_o), 32'd1);
      #1 rst = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy_o), 32'd0);
      check("mid_rst_rsp", 32'(rsp_valid_o), 32'd0);
      check("mid_rst_result", 32'(rsp_result_o), 32'd0);
      check("mid_rst_pulses", 32'({core_doSqrt_o, core_doInvSqrt_o}), 32'd0);
      check("mid_rst_core_f", 32'(core_f_o), 32'd0);
      check("mid_rst_ready", 32'(req_ready_o), 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      start_req(2'b11, 2'b00, 9'h011, 9'h022, 2'b01, 2'b11, 1'b0);
      finish_rsp(LAT);
      @(negedge clk);

      // Stray core valid in IDLE.
      @(posedge clk); #1;
      force_valid = 1'b1;
      @(posedge clk); #1;
      force_valid = 1'b0;
      @(negedge clk);
      check("stray_busy", 32'(busy_o), 32'd0);
      check("stray_rsp", 32'(rsp_valid_o), 32'd0);
`ifdef LAMP_SQRT_ARB_WDOG_EN
      check("stray_wdog", 32'(wdog_err_o), 32'd1);
      // Core never answers: watchdog forces a zero response.
      core_en = 1'b0;
      start_req(2'b01, 2'b00, 9'h077, 9'h000, 2'b01, 2'b11, 1'b1);
      finish_rsp(int'(LAMP_SQRT_ARB_WDOG_CYC) + 2);
      core_en = 1'b1;
      @(negedge clk);
      check("wdog_idle", 32'(busy_o), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
